// File: rtl/seven_seg_scan_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seven_seg_scan_ctrl_pkg : shared state encoding, codes, helpers  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package seven_seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Width needed to count 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_lz_mask_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lz_mask_gen : leading-zero blank mask from shadow BCD digits     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lz_mask_gen
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   blank_mask
);

  // zero_run[i]: digit i and every more significant digit are zero.
  logic [NUM_DIGITS-1:1] zero_run;

  generate
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_digit
      if (i == NUM_DIGITS - 1) begin : g_msd
        assign zero_run[i] = lz_blank && (digits[4*i +: 4] == 4'h0);
      end else begin : g_lower
        assign zero_run[i] = zero_run[i+1] && (digits[4*i +: 4] == 4'h0);
      end
    end
  endgenerate

  // Units digit is always shown so a zero value still reads "0".
  assign blank_mask = {zero_run, 1'b0};

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seven_seg_scan_ctrl : multiplexed 7-seg scanner with guard gaps  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SHOW_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    lz_blank,
  input  logic                    update_req,
  output logic                    update_ack,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);

  localparam int CNT_W = clog2(max2(SHOW_CYCLES, GUARD_CYCLES));
  localparam int IDX_W = clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] C_SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] C_IDX_TOP    = IDX_W'(NUM_DIGITS - 1);

  scan_state_e               state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic                      lz_q, lz_d;
  logic                      pend_q, pend_d;
  logic [3:0]                bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0]     digit_en_n_q, digit_en_n_d;
  logic                      frame_done_q, frame_done_d;
  logic                      update_ack_q, update_ack_d;

  logic                      frame_end;
  logic                      load;
  logic [NUM_DIGITS-1:0]     blank_mask;

  lz_mask_gen #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask_gen (
    .digits     (shadow_q),
    .lz_blank   (lz_q),
    .blank_mask (blank_mask)
  );

  // Sequencing: slot = GUARD_CYCLES blank clocks then SHOW_CYCLES lit clocks.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = C_IDX_TOP;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GUARD;
          idx_d   = C_IDX_TOP;
          cnt_d   = '0;
        end
        ST_GUARD: begin
          if (cnt_q == C_GUARD_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == C_SHOW_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            if (idx_q == '0) begin
              idx_d     = C_IDX_TOP;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q - 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = C_IDX_TOP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A request seen mid-frame is held pending until the next frame boundary.
  assign load = (update_req || pend_q) && (frame_end || (state_q == ST_IDLE));

  always_comb begin
    shadow_d     = shadow_q;
    lz_d         = lz_q;
    pend_d       = (pend_q || update_req) && !load;
    update_ack_d = load;
    frame_done_d = frame_end;
    if (load) begin
      shadow_d = digits_in;
      lz_d     = lz_blank;
    end
  end

  // Outputs are derived from the next state so anode and code switch together.
  always_comb begin
    digit_en_n_d = '1;
    bcd_out_d    = BLANK_CODE;
    if (state_d == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          digit_en_n_d[i] = 1'b0;
          bcd_out_d       = blank_mask[i] ? BLANK_CODE : shadow_q[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= C_IDX_TOP;
      cnt_q        <= '0;
      shadow_q     <= '0;
      lz_q         <= 1'b0;
      pend_q       <= 1'b0;
      bcd_out_q    <= BLANK_CODE;
      digit_en_n_q <= '1;
      frame_done_q <= 1'b0;
      update_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      lz_q         <= lz_d;
      pend_q       <= pend_d;
      bcd_out_q    <= bcd_out_d;
      digit_en_n_q <= digit_en_n_d;
      frame_done_q <= frame_done_d;
      update_ack_q <= update_ack_d;
    end
  end

  assign bcd_out    = bcd_out_q;
  assign digit_en_n = digit_en_n_q;
  assign frame_done = frame_done_q;
  assign update_ack = update_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_seven_seg_scan_ctrl : directed bench, 4 digits, SHOW=4 GUARD=2|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;
  localparam int S = 4;
  localparam int G = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic          lz_blank = 1'b0;
  logic          update_req = 1'b0;
  logic          update_ack;
  logic [3:0]    bcd_out;
  logic [N-1:0]  digit_en_n;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SHOW_CYCLES  (S),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digits_in  (digits_in),
    .lz_blank   (lz_blank),
    .update_req (update_req),
    .update_ack (update_ack),
    .bcd_out    (bcd_out),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (!$onehot0(~digit_en_n)) begin
        errors++;
        $display("FAIL anode_onehot actual=%b required at most one low", digit_en_n);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; update_req = 1'b1; digits_in = 16'h1234; lz_blank = 1'b1;
    tick(); tick();
    checks++; if (digit_en_n !== 4'hF) begin errors++; $display("FAIL reset_anodes actual=%b required=1111", digit_en_n); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("FAIL reset_bcd actual=%h required=f", bcd_out); end
    checks++; if (update_ack !== 1'b0) begin errors++; $display("FAIL reset_ack actual=%b required=0", update_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done actual=%b required=0", frame_done); end
    reset = 1'b0; enable = 1'b0; update_req = 1'b0; lz_blank = 1'b0;
    mon_on = 1'b1;
    tick();
  endtask

  task automatic test_scan();
    logic [15:0] exp_word;
    logic [3:0]  an_exp, bcd_exp;
    logic        fd_exp;
    int s, c;
    exp_word = 16'h1234;
    digits_in = 16'h1234; lz_blank = 1'b0; update_req = 1'b1;
    tick();
    checks++; if (update_ack !== 1'b1) begin errors++; $display("FAIL scan_idle_ack actual=%b required=1", update_ack); end
    update_req = 1'b0; enable = 1'b1;
    for (int t = 1; t <= 49; t++) begin
      tick();
      s = ((t - 1) / 6) % 4;
      c = (t - 1) % 6;
      an_exp  = (c < 2) ? 4'hF : ~(4'b1000 >> s);
      bcd_exp = (c < 2) ? 4'hF : exp_word[15-4*s -: 4];
      fd_exp  = (t == 25) || (t == 49);
      checks++; if (digit_en_n !== an_exp) begin errors++; $display("FAIL scan_anodes t=%0d actual=%b required=%b", t, digit_en_n, an_exp); end
      checks++; if (bcd_out !== bcd_exp) begin errors++; $display("FAIL scan_bcd t=%0d actual=%h required=%h", t, bcd_out, bcd_exp); end
      checks++; if (frame_done !== fd_exp) begin errors++; $display("FAIL scan_frame_done t=%0d actual=%b required=%b", t, frame_done, fd_exp); end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] case_digits [4];
    logic        case_lz     [4];
    logic [15:0] case_exp    [4];
    logic [15:0] exp_word;
    logic [3:0]  bcd_exp;
    int s, c;
    case_digits = '{16'h0050, 16'h0050, 16'h0A0C, 16'h0000};
    case_lz     = '{1'b1,     1'b0,     1'b1,     1'b1};
    case_exp    = '{16'hFF50, 16'h0050, 16'hFA0C, 16'hFFF0};
    for (int k = 0; k < 4; k++) begin
      enable = 1'b0;
      tick();
      checks++; if (digit_en_n !== 4'hF) begin errors++; $display("FAIL lz_idle_anodes case=%0d actual=%b required=1111", k, digit_en_n); end
      digits_in = case_digits[k]; lz_blank = case_lz[k]; update_req = 1'b1;
      tick();
      checks++; if (update_ack !== 1'b1) begin errors++; $display("FAIL lz_ack case=%0d actual=%b required=1", k, update_ack); end
      update_req = 1'b0; enable = 1'b1;
      exp_word = case_exp[k];
      for (int t = 1; t <= 24; t++) begin
        tick();
        s = (t - 1) / 6;
        c = (t - 1) % 6;
        bcd_exp = (c < 2) ? 4'hF : exp_word[15-4*s -: 4];
        checks++; if (bcd_out !== bcd_exp) begin errors++; $display("FAIL lz_bcd case=%0d t=%0d actual=%h required=%h", k, t, bcd_out, bcd_exp); end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_update_mid_frame();
    enable = 1'b0;
    tick();
    digits_in = 16'h1234; lz_blank = 1'b0; update_req = 1'b1;
    tick();
    update_req = 1'b0; enable = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    digits_in = 16'h9999; update_req = 1'b1;
    tick();
    update_req = 1'b0;
    checks++; if (update_ack !== 1'b0) begin errors++; $display("FAIL mid_ack_early t=11 actual=%b required=0", update_ack); end
    for (int t = 12; t <= 30; t++) begin
      tick();
      if (t < 25) begin
        checks++; if (update_ack !== 1'b0) begin errors++; $display("FAIL mid_ack_early t=%0d actual=%b required=0", t, update_ack); end
      end
      if (t == 21) begin
        checks++; if (bcd_out !== 4'h4) begin errors++; $display("FAIL mid_old_digit actual=%h required=4", bcd_out); end
      end
      if (t == 25) begin
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL mid_frame_done actual=%b required=1", frame_done); end
        checks++; if (update_ack !== 1'b1) begin errors++; $display("FAIL mid_ack actual=%b required=1", update_ack); end
      end
      if (t == 27) begin
        checks++; if (digit_en_n !== 4'b0111) begin errors++; $display("FAIL mid_new_anodes actual=%b required=0111", digit_en_n); end
        checks++; if (bcd_out !== 4'h9) begin errors++; $display("FAIL mid_new_digit actual=%h required=9", bcd_out); end
      end
    end
  endtask

  task automatic test_update_held();
    logic [15:0] exp_word;
    logic [3:0]  bcd_exp;
    logic        ack_exp, fd_exp;
    int s, c;
    exp_word = 16'h2468;
    enable = 1'b0;
    tick();
    digits_in = 16'h2468; update_req = 1'b1; enable = 1'b1;
    for (int t = 1; t <= 49; t++) begin
      tick();
      s = ((t - 1) / 6) % 4;
      c = (t - 1) % 6;
      fd_exp  = (t == 25) || (t == 49);
      ack_exp = (t == 1) || fd_exp;
      bcd_exp = (c < 2) ? 4'hF : exp_word[15-4*s -: 4];
      checks++; if (update_ack !== ack_exp) begin errors++; $display("FAIL held_ack t=%0d actual=%b required=%b", t, update_ack, ack_exp); end
      checks++; if (bcd_out !== bcd_exp) begin errors++; $display("FAIL held_bcd t=%0d actual=%h required=%h", t, bcd_out, bcd_exp); end
    end
    update_req = 1'b0;
    digits_in = 16'h9999;
    enable = 1'b0;
    tick();
    update_req = 1'b1;
    tick();
    update_req = 1'b0;
  endtask

  task automatic test_enable_drop();
    enable = 1'b1;
    for (int t = 1; t <= 10; t++) tick();
    checks++; if (digit_en_n !== 4'b1011) begin errors++; $display("FAIL drop_pre_anodes actual=%b required=1011", digit_en_n); end
    checks++; if (bcd_out !== 4'h9) begin errors++; $display("FAIL drop_pre_bcd actual=%h required=9", bcd_out); end
    enable = 1'b0;
    tick();
    checks++; if (digit_en_n !== 4'hF) begin errors++; $display("FAIL drop_anodes actual=%b required=1111", digit_en_n); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("FAIL drop_bcd actual=%h required=f", bcd_out); end
    enable = 1'b1;
    tick();
    checks++; if (digit_en_n !== 4'hF) begin errors++; $display("FAIL restart_guard1 actual=%b required=1111", digit_en_n); end
    tick();
    checks++; if (digit_en_n !== 4'hF) begin errors++; $display("FAIL restart_guard2 actual=%b required=1111", digit_en_n); end
    tick();
    checks++; if (digit_en_n !== 4'b0111) begin errors++; $display("FAIL restart_msd actual=%b required=0111", digit_en_n); end
    checks++; if (bcd_out !== 4'h9) begin errors++; $display("FAIL restart_bcd actual=%h required=9", bcd_out); end
  endtask

  task automatic test_reset_mid();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int t = 1; t <= 4; t++) tick();
    checks++; if (digit_en_n !== 4'b0111) begin errors++; $display("FAIL rst_mid_pre actual=%b required=0111", digit_en_n); end
    reset = 1'b1; update_req = 1'b1; digits_in = 16'h7777;
    tick();
    checks++; if (digit_en_n !== 4'hF) begin errors++; $display("FAIL rst_mid_anodes actual=%b required=1111", digit_en_n); end
    checks++; if (bcd_out !== 4'hF) begin errors++; $display("FAIL rst_mid_bcd actual=%h required=f", bcd_out); end
    checks++; if (update_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack actual=%b required=0", update_ack); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_done actual=%b required=0", frame_done); end
    reset = 1'b0; update_req = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++; if (update_ack !== 1'b0) begin errors++; $display("FAIL rst_post_ack t=%0d actual=%b required=0", t, update_ack); end
    end
    checks++; if (digit_en_n !== 4'b0111) begin errors++; $display("FAIL rst_post_anodes actual=%b required=0111", digit_en_n); end
    checks++; if (bcd_out !== 4'h0) begin errors++; $display("FAIL rst_post_shadow actual=%h required=0", bcd_out); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz_blank();
    test_update_mid_frame();
    test_update_held();
    test_enable_drop();
    test_reset_mid();
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SHOW_CYCLES, default 50000, clocks each digit is driven per scan slot (>=2).
REQ-003 SHALL have parameter GUARD_CYCLES, default 16, all-digits-off clocks between slots (>=1).
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  scanning runs while high.
REQ-007 SHALL have port digits_in  input  4*NUM_DIGITS  BCD digits; digit 0 in bits [3:0]; digit NUM_DIGITS-1 is most significant.
REQ-008 SHALL have port lz_blank  input  1  leading-zero blanking enable, sampled with digits_in.
REQ-009 SHALL have port update_req  input  1  request to load digits_in/lz_blank into the shadow register.
REQ-010 SHALL have port update_ack  output  1  one-cycle pulse when the shadow load occurs.
REQ-011 SHALL have port bcd_out  output  4  code to the shared seven-segment decoder; 4'hF forces a blank.
REQ-012 SHALL have port digit_en_n  output  NUM_DIGITS  active-low digit anode selects, at most one low.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 SHALL implement FSM states IDLE, GUARD, SHOW.
REQ-015 IDLE: digit_en_n all ones, bcd_out 4'hF; enable high -> GUARD with digit index NUM_DIGITS-1 and counter 0.
REQ-016 GUARD: digit_en_n all ones; after exactly GUARD_CYCLES clocks -> SHOW.
REQ-017 SHOW: exactly one digit_en_n bit low, the one matching the digit index; bcd_out = shadow digit or 4'hF if blanked; lasts exactly SHOW_CYCLES clocks.
REQ-018 At the end of SHOW, the digit index SHALL decrement; from index 0 it SHALL wrap to NUM_DIGITS-1, and frame_done SHALL pulse in that same cycle.
REQ-019 Scan order SHALL be most significant digit to digit 0; one frame = NUM_DIGITS*(SHOW_CYCLES+GUARD_CYCLES) clocks.
REQ-020 Shadow load SHALL happen only in the frame_done cycle, or in any cycle while in IDLE, when update_req is high; update_ack SHALL pulse in that cycle; the new value SHALL be displayed from the next slot onward.
REQ-021 update_req SHALL be level-sensitive; if held high, a load occurs at every eligible cycle; a request is never lost, only deferred to the next frame boundary.
REQ-022 Leading-zero blanking: with lz_blank set, digit i SHALL be blanked when it and all more significant shadow digits equal 0; digit 0 SHALL never be blanked.
REQ-023 Shadow digits greater than 9 SHALL pass through unchanged as bcd_out; downstream blanking is the decoder's job.
REQ-024 enable low in any state SHALL cause a transition to IDLE on the next clock, with outputs blanked in that same next cycle; no partial-slot completion.
REQ-025 bcd_out and digit_en_n SHALL be registered and change in the same clock, never producing a cycle where an enabled digit shows the previous digit's code.
REQ-026 Counter width SHALL be clog2 of max(SHOW_CYCLES, GUARD_CYCLES); the index width SHALL be clog2(NUM_DIGITS).

Reset
REQ-027 reset SHALL force IDLE, index NUM_DIGITS-1, counter 0, shadow all 4'h0, shadow lz_blank 0.
REQ-028 Reset outputs: digit_en_n all ones, bcd_out 4'hF, update_ack 0, frame_done 0.
REQ-029 reset SHALL take priority over enable and update_req in the same cycle, including mid-slot.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the BLANK_CODE constant 4'hF, and the clog2 helper function.
REQ-031 Leading-zero mask generation SHALL be a combinational sub-module lz_mask_gen (shadow digits in, blank mask out); the decoder itself stays outside this block.

Verification
REQ-032 NUM_DIGITS=4, SHOW=4, GUARD=2; digits 1,2,3,4; enable=1 -> anodes 4'b0111,1011,1101,1110 each low for 4 clocks, with 2 all-high clocks between; frame_done every 24 clocks.
REQ-033 Digits 0,0,5,0 (MSB first), lz_blank=1 -> bcd_out F,F,5,0; with lz_blank=0 -> 0,0,5,0.
REQ-034 update_req pulsed mid-frame with new digits 9,9,9,9 -> update_ack only at the next frame_done; the following slot shows 9.
REQ-035 enable dropped during SHOW of digit 2 -> next cycle anodes 4'b1111 and bcd_out F; re-enable -> restart from digit 3 after 2 guard clocks.
REQ-036 reset asserted mid-SHOW with update_req=1 -> outputs at reset values next cycle, no update_ack, shadow reads 0.
REQ-037 All configurations -> assert digit_en_n never has more than one bit low.
